friscv_apb_initiator: RTL and testbench
=======================================

# friscv_apb_initiator

Initiator side of the peripheral control bus used by the UART and other friscv APB peripherals. It converts a valid/ready request/response channel from the core's load/store path into the single-outstanding `mst_en`/`mst_ready` handshake.

- Holds every request stable until the peripheral acknowledges it.
- Captures read data on the acknowledge cycle and returns it on a buffered response channel.
- Optionally aborts requests that the peripheral never acknowledges.

## Interface

Parameters:
- `ADDRW`, 16: peripheral address width.
- `XLEN`, 32: data width; strobe width is `XLEN/8`.
- `TIMEOUT`, 1024: number of cycles waited in REQ before abort. Legal range is 1..65535. Used only with `FRISCV_APB_TIMEOUT_EN`.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `srst`  in  1  synchronous reset, active-high. Same effect as `aresetn`.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when `req_valid` is also high.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_addr`  in  `ADDRW`  register address.
- `req_wdata`  in  `XLEN`  write data.
- `req_strb`  in  `XLEN/8`  write byte strobes.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  `XLEN`  read data; 0 for writes and for errors.
- `rsp_err`  out  1  request timed out.
- `mst_en`  out  1  bus request to the peripheral.
- `mst_wr`, `mst_addr`, `mst_wdata`, `mst_strb`  out  1 / `ADDRW` / `XLEN` / `XLEN/8`  registered copy of the accepted request.
- `mst_rdata`  in  `XLEN`  peripheral read data; valid only when `mst_ready` = 1.
- `mst_ready`  in  1  single-cycle acknowledge from the peripheral.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation

FSM states: IDLE, REQ, RSP.

- **IDLE**
  - `req_ready` = 1, `mst_en` = 0.
  - On `req_valid`: latch `wr`/`addr`/`wdata`/`strb` onto the `mst_*` outputs, set `mst_en` = 1, clear the timeout counter, go to REQ.
- **REQ**
  - `mst_en` = 1; all `mst_*` outputs are held stable.
  - On `mst_ready` = 1:
    - `mst_en` <= 0.
    - `rsp_rdata` <= `mst_rdata` for a read, 0 for a write.
    - `rsp_err` <= 0, `rsp_valid` <= 1, go to RSP.
  - Otherwise the timeout counter increments by 1 per cycle.
- **RSP**
  - `rsp_valid` = 1; `rsp_rdata` and `rsp_err` are held.
  - On `rsp_ready`: `rsp_valid` <= 0, go to IDLE.
- `mst_ready` seen in IDLE or RSP (spurious or late acknowledge) is ignored; it does not change state or data.
- Exactly one transaction is outstanding at a time. `req_ready` = 0 in REQ and RSP.
- Blocking peripherals (a full TX FIFO, an empty RX FIFO) simply extend REQ.
- Reset values:
  - `req_ready` = 0 during reset, 1 in the first cycle after reset.
  - `rsp_valid` = 0, `rsp_err` = 0, `rsp_rdata` = 0, `mst_en` = 0, `mst_wr` = 0, `mst_addr` = 0, `mst_wdata` = 0, `mst_strb` = 0, `busy` = 0.
  - State = IDLE.
- Reset (`aresetn` low or `srst` high) in the middle of a transaction returns the FSM to IDLE immediately and drops `mst_en` with no response. The peripheral is reset by the same signals.

## Timing

- All outputs are registered except `req_ready` and `busy`, which are decoded directly from the state.
- Zero-wait peripheral (acknowledges one cycle after sampling `mst_en`):
  - Request accepted at edge 0.
  - `mst_en` high after edge 0.
  - `mst_ready` high after edge 1.
  - `rsp_valid` high after edge 2.
  - Latency from accept to `rsp_valid` is 3 cycles.
- `mst_en` falls in the same cycle `rsp_valid` rises. The peripheral ignores `mst_en` in the cycle after its acknowledge, so no duplicate request is issued.
- With `rsp_ready` tied high, the maximum throughput is 1 transaction per 4 cycles.
- Read data is sampled only on the `mst_ready` cycle and is not tracked afterwards.

## Configuration

- `FRISCV_APB_TIMEOUT_EN` defined:
  - A 16-bit counter runs while in REQ.
  - When the counter reaches `TIMEOUT - 1` with `mst_ready` = 0: `mst_en` <= 0, `rsp_err` <= 1, `rsp_rdata` <= 0, go to RSP.
  - If `mst_ready` = 1 in that same cycle, the acknowledge wins and `rsp_err` = 0.
- Not defined:
  - No counter; REQ waits forever.
  - `rsp_err` is constant 0.

## Structure

- Shared package/header `friscv_h.sv` holds:
  - the FSM state typedef (IDLE/REQ/RSP encoding);
  - the default timeout constant.
- No sub-module: a single FSM plus output registers (about 150-250 lines).
- A response FIFO is not needed, because only one transaction is ever outstanding.

## Test plan

- **Write then read back, through the real UART peripheral.** Write 0x0000_00A0 to addr 1, strb 0x3, then read addr 1 -> `rsp_rdata` = 0x0000_00A0, `rsp_err` = 0, read response 3 cycles after accept.
- **Write response data.** Write addr 0, wdata 0x1, strb 0x1 -> response with `rsp_rdata` = 0; a subsequent read of addr 0 returns bit0 = 1.
- **Blocking read.** Read addr 3 with the RX FIFO empty -> `mst_en` held and `busy` = 1 for 200 cycles; drive an RX byte 0x5A -> `rsp_rdata` = 0x5A.
- **Response backpressure.** `rsp_ready` = 0 for 10 cycles -> `rsp_valid` and `rsp_rdata` stable, `req_ready` = 0, `mst_en` = 0; then `rsp_ready` = 1 -> IDLE the next cycle.
- **Timeout** (`FRISCV_APB_TIMEOUT_EN`, `TIMEOUT` = 16, stub peripheral never acknowledges):
  - `rsp_err` = 1 and `rsp_rdata` = 0 exactly 16 cycles after `mst_en` rises.
  - A late `mst_ready` in IDLE is ignored.
  - A stub acknowledge on the 16th cycle -> `rsp_err` = 0.
- **Reset mid-request.** Assert `srst` in REQ -> `mst_en` = 0, `rsp_valid` = 0 and state IDLE the next cycle; a fresh request then completes normally.

Source files
------------

// File: rtl/friscv_apb_initiator_pkg.sv
// Shared types for the friscv peripheral-bus initiator: FSM state encoding
// and the default abort timeout.
package friscv_apb_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } apb_state_t;

  localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/friscv_apb_initiator_if.sv
// Request/response channel from the core plus the mst_* peripheral bus.
// The master modport is the initiator's view; slave is the opposite side.
interface friscv_apb_initiator_if #(
  parameter int ADDRW = 16,
  parameter int XLEN  = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDRW-1:0]  req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN/8-1:0] req_strb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  logic              mst_en;
  logic              mst_wr;
  logic [ADDRW-1:0]  mst_addr;
  logic [XLEN-1:0]   mst_wdata;
  logic [XLEN/8-1:0] mst_strb;
  logic [XLEN-1:0]   mst_rdata;
  logic              mst_ready;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, req_strb,
    input  rsp_ready, mst_rdata, mst_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mst_en, mst_wr, mst_addr, mst_wdata, mst_strb
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, req_strb,
    output rsp_ready, mst_rdata, mst_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mst_en, mst_wr, mst_addr, mst_wdata, mst_strb
  );

endinterface

// File: rtl/friscv_apb_initiator.sv
// Single-outstanding initiator: valid/ready request channel to mst_en/mst_ready.
// Define FRISCV_APB_TIMEOUT_EN to abort requests never acknowledged within TIMEOUT cycles.
module friscv_apb_initiator
  import friscv_apb_initiator_pkg::*;
#(
  parameter int ADDRW   = 16,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   srst,
  friscv_apb_initiator_if.master bus,
  output logic                   busy
);

  typedef struct packed {
    logic              mst_en;
    logic              mst_wr;
    logic [ADDRW-1:0]  mst_addr;
    logic [XLEN-1:0]   mst_wdata;
    logic [XLEN/8-1:0] mst_strb;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
  } out_regs_t;

  apb_state_t state;
  out_regs_t  q;

`ifdef FRISCV_APB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] to_cnt;
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT);
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
      q     <= '0;
`ifdef FRISCV_APB_TIMEOUT_EN
      to_cnt <= '0;
`endif
    end else if (srst) begin
      state <= ST_IDLE;
      q     <= '0;
`ifdef FRISCV_APB_TIMEOUT_EN
      to_cnt <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            q.mst_en    <= 1'b1;
            q.mst_wr    <= bus.req_wr;
            q.mst_addr  <= bus.req_addr;
            q.mst_wdata <= bus.req_wdata;
            q.mst_strb  <= bus.req_strb;
`ifdef FRISCV_APB_TIMEOUT_EN
            to_cnt <= '0;
`endif
            state <= ST_REQ;
          end
        end
        // Acknowledge has priority over the abort in the same cycle
        ST_REQ: begin
          if (bus.mst_ready) begin
            q.mst_en    <= 1'b0;
            q.rsp_rdata <= q.mst_wr ? '0 : bus.mst_rdata;
            q.rsp_err   <= 1'b0;
            q.rsp_valid <= 1'b1;
            state       <= ST_RSP;
          end
`ifdef FRISCV_APB_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            q.mst_en    <= 1'b0;
            q.rsp_rdata <= '0;
            q.rsp_err   <= 1'b1;
            q.rsp_valid <= 1'b1;
            state       <= ST_RSP;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        ST_RSP: begin
          if (bus.rsp_ready) begin
            q.rsp_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // req_ready must stay low while either reset is asserted
  assign bus.req_ready = (state == ST_IDLE) && aresetn && !srst;
  assign busy          = (state != ST_IDLE);

  assign bus.mst_en    = q.mst_en;
  assign bus.mst_wr    = q.mst_wr;
  assign bus.mst_addr  = q.mst_addr;
  assign bus.mst_wdata = q.mst_wdata;
  assign bus.mst_strb  = q.mst_strb;
  assign bus.rsp_valid = q.rsp_valid;
  assign bus.rsp_rdata = q.rsp_rdata;
  assign bus.rsp_err   = q.rsp_err;

endmodule

// File: tb/tb_friscv_apb_initiator.sv
// Directed bench for friscv_apb_initiator with a small register/RX peripheral model
// and a controllable stub acknowledge; timeout scenarios need FRISCV_APB_TIMEOUT_EN.
module tb_friscv_apb_initiator;

  localparam int ADDRW   = 16;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic srst    = 1'b0;
  logic busy;

  always #5 aclk = ~aclk;

  friscv_apb_initiator_if #(.ADDRW(ADDRW), .XLEN(XLEN)) bus ();

  friscv_apb_initiator #(.ADDRW(ADDRW), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .bus     (bus),
    .busy    (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Peripheral model: four byte-strobed registers, addr 3 reads block until rx_avail
  logic        stub_mode = 1'b0;
  logic        stub_ack  = 1'b0;
  logic        rx_avail  = 1'b0;
  logic [7:0]  rx_byte   = 8'h00;
  logic [31:0] pregs [4];

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn || srst) begin
      bus.mst_ready <= 1'b0;
      bus.mst_rdata <= '0;
      for (int i = 0; i < 4; i++) pregs[i] <= '0;
    end else if (stub_mode) begin
      bus.mst_ready <= stub_ack;
      bus.mst_rdata <= 32'h0000_0077;
    end else begin
      bus.mst_ready <= 1'b0;
      if (bus.mst_en && !bus.mst_ready) begin
        if (bus.mst_wr) begin
          for (int b = 0; b < 4; b++)
            if (bus.mst_strb[b]) pregs[bus.mst_addr[1:0]][8*b +: 8] <= bus.mst_wdata[8*b +: 8];
          bus.mst_ready <= 1'b1;
          bus.mst_rdata <= 32'hDEAD_BEEF;
        end else if (bus.mst_addr[1:0] == 2'd3) begin
          if (rx_avail) begin
            bus.mst_ready <= 1'b1;
            bus.mst_rdata <= {24'h0, rx_byte};
          end
        end else begin
          bus.mst_ready <= 1'b1;
          bus.mst_rdata <= pregs[bus.mst_addr[1:0]];
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Issue one request; lat counts edges from the accept edge (1) to rsp_valid, -1 if none
  task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                        output int lat);
    int guard;
    guard         = 0;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_strb  = strb;
    while (!bus.req_ready && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 500) begin
      tick();
      lat++;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    if (!bus.rsp_valid) lat = -1;
    tick();
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req_ready: got %b want 0", bus.req_ready);
    end
    n_cmp++;
    if ({bus.mst_en, bus.mst_wr, bus.mst_addr, bus.mst_wdata, bus.mst_strb,
         bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%b wr=%b addr=%h wdata=%h strb=%h rv=%b err=%b rdata=%h busy=%b want all 0",
               bus.mst_en, bus.mst_wr, bus.mst_addr, bus.mst_wdata, bus.mst_strb,
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, busy);
    end
    tick();
    aresetn = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_req_ready: got %b want 1", bus.req_ready);
    end
    tick();
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_txn(1'b1, 16'd1, 32'h0000_00A0, 4'h3, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h want 00000000", rd); end
    n_cmp++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", er); end
    n_cmp++;
    if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d want 3", lat); end
    do_txn(1'b0, 16'd1, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h0000_00A0) begin n_fail++; $display("FAIL rd_rdata: got %h want 000000a0", rd); end
    n_cmp++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", er); end
    n_cmp++;
    if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", lat); end
  endtask

  task automatic test_write_strobe();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_txn(1'b1, 16'd0, 32'h0000_0001, 4'h1, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL wr0_rdata: got %h want 00000000", rd); end
    do_txn(1'b0, 16'd0, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h0000_0001) begin n_fail++; $display("FAIL rd0_rdata: got %h want 00000001", rd); end
    do_txn(1'b1, 16'd2, 32'hFFFF_FFFF, 4'h2, rd, er, lat);
    do_txn(1'b0, 16'd2, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h0000_FF00) begin n_fail++; $display("FAIL strb_byte1: got %h want 0000ff00", rd); end
  endtask

  task automatic test_blocking_read();
    logic ok;
    int   guard;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 16'd3;
    bus.req_wdata = 32'h0;
    bus.req_strb  = 4'h0;
    tick();
    bus.req_valid = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!(bus.mst_en === 1'b1 && busy === 1'b1 && bus.mst_addr === 16'd3 &&
            bus.mst_wr === 1'b0 && bus.rsp_valid === 1'b0 && bus.req_ready === 1'b0)) ok = 1'b0;
      tick();
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL block_hold: en=%b busy=%b addr=%h rv=%b want en=1 busy=1 addr=0003 rv=0",
               bus.mst_en, busy, bus.mst_addr, bus.rsp_valid);
    end
    rx_byte  = 8'h5A;
    rx_avail = 1'b1;
    guard    = 0;
    while (!bus.rsp_valid && guard < 10) begin
      tick();
      guard++;
    end
    rx_avail = 1'b0;
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0000_005A) begin
      n_fail++;
      $display("FAIL block_rdata: rv=%b rdata=%h want rv=1 rdata=0000005a", bus.rsp_valid, bus.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        ok;
    bus.rsp_ready = 1'b0;
    do_txn(1'b0, 16'd1, 32'h0, 4'h0, rd, er, lat);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(bus.rsp_valid === 1'b1 && bus.rsp_rdata === 32'h0000_00A0 && bus.req_ready === 1'b0 &&
            bus.mst_en === 1'b0 && busy === 1'b1)) ok = 1'b0;
      tick();
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: rv=%b rdata=%h rr=%b en=%b want rv=1 rdata=000000a0 rr=0 en=0",
               bus.rsp_valid, bus.rsp_rdata, bus.req_ready, bus.mst_en);
    end
    bus.rsp_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: rv=%b busy=%b rr=%b want rv=0 busy=0 rr=1", bus.rsp_valid, busy, bus.req_ready);
    end
  endtask

  task automatic test_spurious_ack();
    stub_mode = 1'b1;
    stub_ack  = 1'b1;
    tick();
    stub_ack = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0000_00A0) begin
      n_fail++;
      $display("FAIL spurious_idle: busy=%b rv=%b rdata=%h want busy=0 rv=0 rdata=000000a0",
               busy, bus.rsp_valid, bus.rsp_rdata);
    end
    stub_mode = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        er;
    int          lat;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 16'd3;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.mst_en !== 1'b1) begin n_fail++; $display("FAIL mid_pending: en=%b want 1", bus.mst_en); end
    srst = 1'b1;
    tick();
    n_cmp++;
    if (bus.mst_en !== 1'b0 || bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_srst: en=%b rv=%b busy=%b rr=%b want 0 0 0 0", bus.mst_en, bus.rsp_valid, busy, bus.req_ready);
    end
    srst = 1'b0;
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", bus.req_ready); end
    do_txn(1'b1, 16'd2, 32'h1234_5678, 4'hF, rd, er, lat);
    do_txn(1'b0, 16'd2, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h1234_5678 || lat !== 3) begin
      n_fail++;
      $display("FAIL mid_fresh: rdata=%h lat=%0d want 12345678 3", rd, lat);
    end
  endtask

`ifdef FRISCV_APB_TIMEOUT_EN
  task automatic test_timeout();
    logic ok;
    stub_mode     = 1'b1;
    stub_ack      = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 16'd5;
    tick();
    bus.req_valid = 1'b0;
    ok = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || bus.mst_en !== 1'b1) ok = 1'b0;
    end
    n_cmp++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL to_early: rv=%b en=%b want 0 1", bus.rsp_valid, bus.mst_en); end
    tick();
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.mst_en !== 1'b0) begin
      n_fail++;
      $display("FAIL to_abort: rv=%b err=%b rdata=%h en=%b want 1 1 00000000 0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.mst_en);
    end
    tick();
    stub_ack = 1'b1;
    tick();
    stub_ack = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL to_late_ack: busy=%b rv=%b want 0 0", busy, bus.rsp_valid);
    end
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 14; k++) tick();
    stub_ack = 1'b1;
    tick();
    stub_ack = 1'b0;
    tick();
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0000_0077) begin
      n_fail++;
      $display("FAIL to_ack_wins: rv=%b err=%b rdata=%h want 1 0 00000077",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    tick();
    stub_mode = 1'b0;
    tick();
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_write_strobe();
    test_blocking_read();
    test_backpressure();
    test_spurious_ack();
    test_reset_mid();
`ifdef FRISCV_APB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
